// File: rtl/map_pkg.sv
// Shared map definitions: cell value constants and the writer FSM state encoding.
package map_pkg;

    localparam logic [1:0] MAP_EMPTY  = 2'b00;
    localparam logic [1:0] MAP_WALL_A = 2'b01;
    localparam logic [1:0] MAP_WALL_B = 2'b10;
    localparam logic [1:0] MAP_WALL_C = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_SKIP  = 3'd4
    } wr_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the serial link into the clk domain with 2-flop synchronizers and derives
// the sclk-rise and ss_n-fall strobes from a third history flop.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_ss_n,
    output logic o_mosi,
    output logic o_ss_n,
    output logic o_sclk_rise,
    output logic o_ss_fall
);

    logic [2:0] sclk_q, sclk_d;
    logic [1:0] mosi_q, mosi_d;
    logic [2:0] ss_q, ss_d;

    always_comb begin
        sclk_d = {sclk_q[1:0], i_sclk};
        mosi_d = {mosi_q[0], i_mosi};
        ss_d   = {ss_q[1:0], i_ss_n};
    end

    // ss_n history resets high so a reset never looks like a frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            ss_q   <= 3'b111;
        end else begin
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            ss_q   <= ss_d;
        end
    end

    assign o_mosi      = mosi_q[1];
    assign o_ss_n      = ss_q[1];
    assign o_sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign o_ss_fall   = ~ss_q[1] & ss_q[2];

endmodule

// File: rtl/map_ram_writer.sv
// Host-loadable map RAM fed by a 3-wire serial link, with the tracer's combinational lookup.
// Build option MAP_RAM_BORDER_EN: the post-reset clear leaves a closed outer wall.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | sweeping every cell with its clear value, o_busy high
// ST_IDLE  | waiting for ss_n to fall
// ST_ADDR  | shifting in the row/col header, MSB first
// ST_DATA  | shifting 2-bit cells, committing one per pair, address auto-increments
// ST_SKIP  | frame was already open when the clear finished; ignored until ss_n high
module map_ram_writer
    import map_pkg::*;
#(
    parameter int MAP_WBITS = 4,
    parameter int MAP_HBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sclk,
    input  logic                 i_mosi,
    input  logic                 i_ss_n,
    input  logic [MAP_WBITS-1:0] i_col,
    input  logic [MAP_HBITS-1:0] i_row,
    output logic [1:0]           o_val,
    output logic                 o_busy,
    output logic                 o_wr
);

    localparam int AW    = MAP_WBITS + MAP_HBITS;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(AW) + 1;

    logic mosi_s, ss_n_s, sclk_rise, ss_fall;

    spi_sync_edge u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_sclk      (i_sclk),
        .i_mosi      (i_mosi),
        .i_ss_n      (i_ss_n),
        .o_mosi      (mosi_s),
        .o_ss_n      (ss_n_s),
        .o_sclk_rise (sclk_rise),
        .o_ss_fall   (ss_fall)
    );

    wr_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              data_hi_q, data_hi_d;
    logic              busy_q, busy_d;
    logic              wr_q, wr_d;

    logic              ram_we;
    logic [1:0]        ram_wdata;
    logic [1:0]        clear_val;
    logic [1:0]        mem [DEPTH];

`ifdef MAP_RAM_BORDER_EN
    logic [MAP_WBITS-1:0] clr_col;
    logic [MAP_HBITS-1:0] clr_row;

    always_comb begin
        clr_col   = addr_q[MAP_WBITS-1:0];
        clr_row   = addr_q[AW-1:MAP_WBITS];
        clear_val = ((clr_col == '0) || (clr_col == '1) || (clr_row == '0) || (clr_row == '1))
                    ? MAP_WALL_A : MAP_EMPTY;
    end
`else
    assign clear_val = MAP_EMPTY;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_cnt_d = bit_cnt_q;
        data_hi_d = data_hi_q;
        busy_d    = 1'b0;
        wr_d      = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = clear_val;

        case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
                busy_d = 1'b1;
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(DEPTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ss_n_s ? ST_IDLE : ST_SKIP;
                end
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                if (ss_n_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    addr_d    = {addr_q[AW-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(AW - 1)) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (ss_n_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt_q == '0) begin
                        data_hi_d = mosi_s;
                        bit_cnt_d = CW'(1);
                    end else begin
                        // {row,col} increment gives col wrap into row and row wrap to 0
                        ram_we    = 1'b1;
                        ram_wdata = {data_hi_q, mosi_s};
                        wr_d      = 1'b1;
                        addr_d    = addr_q + AW'(1);
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_SKIP: begin
                if (ss_n_s) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                addr_d  = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            addr_q    <= '0;
            bit_cnt_q <= '0;
            data_hi_q <= 1'b0;
            busy_q    <= 1'b1;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_cnt_q <= bit_cnt_d;
            data_hi_q <= data_hi_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ram_we) mem[addr_q] <= ram_wdata;
    end

    assign o_val  = busy_q ? MAP_EMPTY : mem[{i_row, i_col}];
    assign o_busy = busy_q;
    assign o_wr   = wr_q;

endmodule
